// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the load/store master: RV funct3 codes, FSM states, access sizes.
// The optional misalignment trap (LSU_MISALIGN_CHECK_EN) uses the misaligned() helper here.
package lsu_mem_master_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W_DEF = 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_W    = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Undefined funct3 codes fall back to a full word access.
    function automatic size_e load_size(input logic [2:0] op);
        case (op)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic size_e store_size(input logic [2:0] op);
        case (op)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extraction with extension, and
// store data shifting plus byte-strobe generation.
module lsu_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]                op_i,
    input  logic [1:0]                lane_i,
    input  logic [DATA_W_DEF-1:0]     rdata_i,
    input  logic [DATA_W_DEF-1:0]     store_data_i,
    output logic [DATA_W_DEF-1:0]     load_data_o,
    output logic [DATA_W_DEF-1:0]     wdata_o,
    output logic [STRB_W_DEF-1:0]     wstrb_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_ext;
    logic [3:0]  strb4;

    // funct3[2] set means the unsigned load variants.
    always_comb begin
        byte_v      = rdata_i[{lane_i, 3'b000} +: 8];
        half_v      = rdata_i[{lane_i[1], 4'b0000} +: 16];
        sign_ext    = ~op_i[2];
        load_data_o = rdata_i;
        case (load_size(op_i))
            SZ_BYTE: load_data_o = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: load_data_o = {{16{sign_ext & half_v[15]}}, half_v};
            default: load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        wdata_o = store_data_i << {lane_i, 3'b000};
        strb4   = 4'b1111;
        case (store_size(op_i))
            SZ_BYTE: strb4 = 4'b0001 << lane_i;
            SZ_HALF: strb4 = 4'b0011 << {lane_i[1], 1'b0};
            default: strb4 = 4'b1111;
        endcase
        wstrb_o = {4'b0000, strb4};
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store master FSM driving AXI-lite-style read/write channels and a registered
// writeback result. Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses off-bus.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [31:0]       rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic              err_o
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;
    logic              err_q, err_d;
    logic              mis;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] shifted_data;
    logic [STRB_W-1:0] strb;

    lsu_align u_align (
        .op_i         (op_q),
        .lane_i       (addr_q[1:0]),
        .rdata_i      (rdata_i),
        .store_data_i (sdata_q),
        .load_data_o  (ext_data),
        .wdata_o      (shifted_data),
        .wstrb_o      (strb)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = is_load_i ? misaligned(load_size(mem_op_i), addr_i[1:0])
                           : misaligned(store_size(mem_op_i), addr_i[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        sdata_d = sdata_q;
        ldata_d = ldata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = addr_i;
                    op_d    = mem_op_i;
                    sdata_d = store_data_i;
                    ldata_d = '0;
                    err_d   = 1'b0;
                    // A trapped access reports straight to writeback; load wins over store.
                    if ((is_load_i || is_store_i) && mis) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_load_i) begin
                        state_d = ST_AR;
                    end else if (is_store_i) begin
                        state_d = ST_W;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_AR:   if (arready_i) state_d = ST_R;
            ST_R: begin
                if (rvalid_i) begin
                    ldata_d = ext_data;
                    err_d   = (rresp_i != 32'd0);
                    state_d = ST_DONE;
                end
            end
            ST_W:    if (wready_i) state_d = ST_DONE;
            ST_DONE: if (res_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            sdata_q <= sdata_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign arvalid_o   = (state_q == ST_AR);
    assign rready_o    = (state_q == ST_R);
    assign wvalid_o    = (state_q == ST_W);
    assign res_valid_o = (state_q == ST_DONE);
    assign araddr_o    = arvalid_o ? addr_q : '0;
    assign awaddr_o    = wvalid_o ? addr_q : '0;
    assign wdata_o     = wvalid_o ? shifted_data : '0;
    assign wstrb_o     = wvalid_o ? strb : '0;
    assign load_data_o = ldata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed operations with hand-computed results
// plus a transaction-level model checked every cycle. Honours LSU_MISALIGN_CHECK_EN.
module tb_lsu_mem_master;

    localparam int K_NONE  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, is_load_i, is_store_i;
    logic [2:0]  mem_op_i;
    logic [31:0] addr_i, store_data_i, araddr_o, rdata_i, rresp_i, awaddr_o, wdata_o, load_data_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o, wvalid_o, wready_i;
    logic [7:0]  wstrb_o;
    logic        res_valid_o, res_ready_i, err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .mem_op_i(mem_op_i),
        .addr_i(addr_i), .store_data_i(store_data_i),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .load_data_o(load_data_o), .err_o(err_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (rd >> (16 * addr[1])) & 32'h0000_FFFF;
        case (op)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [7:0] modelStrb(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            3'b000:  return 8'h01 << addr[1:0];
            3'b001:  return 8'h03 << (2 * addr[1]);
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] sd, input logic [31:0] addr);
        return sd << (8 * addr[1:0]);
    endfunction

    function automatic bit modelMisaligned(input bit isLoad, input logic [2:0] op, input logic [31:0] addr);
        int nbytes;
        if (isLoad) nbytes = (op == 3'b000 || op == 3'b100) ? 1 : (op == 3'b001 || op == 3'b101) ? 2 : 4;
        else        nbytes = (op == 3'b000) ? 1 : (op == 3'b001) ? 2 : 4;
        return (addr % nbytes) != 0;
    endfunction

    // Transaction model: which channel must be active follows only from the handshakes seen so far.
    bit          mBusy, mArDone, mResKnown, mErr;
    int          mKind;
    logic [2:0]  mOp;
    logic [31:0] mAddr, mSdata, mData;
    bit          expAr, expR, expW, expRes, mis;

    always @(negedge clk) begin
        if (rst) begin
            mBusy = 0; mArDone = 0; mResKnown = 0; mKind = K_NONE;
        end else begin
            expAr  = mBusy && mKind == K_LOAD && !mArDone;
            expR   = mBusy && mKind == K_LOAD && mArDone && !mResKnown;
            expW   = mBusy && mKind == K_STORE && !mResKnown;
            expRes = mBusy && mResKnown;
            checkOutput("model.req_ready", {31'b0, req_ready_o}, {31'b0, !mBusy});
            checkOutput("model.arvalid", {31'b0, arvalid_o}, {31'b0, expAr});
            checkOutput("model.rready", {31'b0, rready_o}, {31'b0, expR});
            checkOutput("model.wvalid", {31'b0, wvalid_o}, {31'b0, expW});
            checkOutput("model.res_valid", {31'b0, res_valid_o}, {31'b0, expRes});
            if (expAr) checkOutput("model.araddr", araddr_o, mAddr);
            if (expW) begin
                checkOutput("model.awaddr", awaddr_o, mAddr);
                checkOutput("model.wdata", wdata_o, modelWdata(mSdata, mAddr));
                checkOutput("model.wstrb", {24'b0, wstrb_o}, {24'b0, modelStrb(mOp, mAddr)});
            end
            if (expRes) begin
                checkOutput("model.load_data", load_data_o, mData);
                checkOutput("model.err", {31'b0, err_o}, {31'b0, mErr});
            end
            if (!mBusy) begin
                if (req_valid_i) begin
                    mBusy = 1; mArDone = 0; mOp = mem_op_i; mAddr = addr_i; mSdata = store_data_i;
                    mData = 0; mErr = 0;
`ifdef LSU_MISALIGN_CHECK_EN
                    mis = (is_load_i || is_store_i) && modelMisaligned(is_load_i, mem_op_i, addr_i);
`else
                    mis = 0;
`endif
                    if (mis) begin
                        mKind = K_NONE; mResKnown = 1; mErr = 1;
                    end else if (is_load_i) begin
                        mKind = K_LOAD; mResKnown = 0;
                    end else if (is_store_i) begin
                        mKind = K_STORE; mResKnown = 0;
                    end else begin
                        mKind = K_NONE; mResKnown = 1;
                    end
                end
            end else if (expRes) begin
                if (res_ready_i) mBusy = 0;
            end else if (expAr) begin
                if (arready_i) mArDone = 1;
            end else if (expR) begin
                if (rvalid_i) begin
                    mResKnown = 1;
                    mData = modelLoad(mOp, mAddr, rdata_i);
                    mErr = (rresp_i != 0);
                end
            end else if (expW) begin
                if (wready_i) mResKnown = 1;
            end
        end
    end

    task automatic applyStimulus(
        input string name, input bit isL, input bit isS, input logic [2:0] op,
        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata, input logic [31:0] rresp,
        input int arD, input int rD, input int wD, input int resHold,
        input int expBus, input logic [31:0] expBusAddr, input logic [31:0] expWdata, input logic [7:0] expStrb,
        input logic [31:0] expData, input bit expErr, input int expLat);
        int cnt, arSeen, rSeen, wSeen, busSeen;
        req_valid_i = 1; is_load_i = isL; is_store_i = isS; mem_op_i = op;
        addr_i = addr; store_data_i = sdata; rdata_i = rdata; rresp_i = rresp;
        tick();
        req_valid_i = 0; is_load_i = 0; is_store_i = 0;
        cnt = 1; arSeen = 0; rSeen = 0; wSeen = 0; busSeen = 0;
        while (res_valid_o !== 1'b1 && cnt < 40) begin
            if (arvalid_o && arSeen == 0) begin
                busSeen = 1;
                checkOutput({name, ".araddr"}, araddr_o, expBusAddr);
            end
            if (wvalid_o && wSeen == 0) begin
                busSeen = 2;
                checkOutput({name, ".awaddr"}, awaddr_o, expBusAddr);
                checkOutput({name, ".wdata"}, wdata_o, expWdata);
                checkOutput({name, ".wstrb"}, {24'b0, wstrb_o}, {24'b0, expStrb});
            end
            arready_i = arvalid_o && (arSeen >= arD); if (arvalid_o) arSeen++;
            rvalid_i  = rready_o && (rSeen >= rD);    if (rready_o) rSeen++;
            wready_i  = wvalid_o && (wSeen >= wD);    if (wvalid_o) wSeen++;
            tick();
            cnt++;
        end
        arready_i = 0; rvalid_i = 0; wready_i = 0;
        checkOutput({name, ".latency"}, cnt, expLat);
        checkOutput({name, ".bus"}, busSeen, expBus);
        checkOutput({name, ".load_data"}, load_data_o, expData);
        checkOutput({name, ".err"}, {31'b0, err_o}, {31'b0, expErr});
        for (int i = 0; i < resHold; i++) begin
            tick();
            checkOutput({name, ".held_valid"}, {31'b0, res_valid_o}, 32'd1);
            checkOutput({name, ".held_data"}, load_data_o, expData);
            checkOutput({name, ".held_req_ready"}, {31'b0, req_ready_o}, 32'd0);
        end
        res_ready_i = 1;
        tick();
        res_ready_i = 0;
        checkOutput({name, ".res_released"}, {31'b0, res_valid_o}, 32'd0);
        checkOutput({name, ".req_ready_back"}, {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        rst = 1; req_valid_i = 0; is_load_i = 0; is_store_i = 0; mem_op_i = 0;
        addr_i = 0; store_data_i = 0; arready_i = 0; rdata_i = 0; rresp_i = 0;
        rvalid_i = 0; wready_i = 0; res_ready_i = 0;
        repeat (3) tick();
        checkOutput("reset.req_ready", {31'b0, req_ready_o}, 32'd1);
        checkOutput("reset.valids", {28'b0, arvalid_o, rready_o, wvalid_o, res_valid_o}, 32'd0);
        checkOutput("reset.load_data", load_data_o, 32'd0);
        checkOutput("reset.err", {31'b0, err_o}, 32'd0);
        checkOutput("reset.wstrb", {24'b0, wstrb_o}, 32'd0);
        checkOutput("reset.araddr", araddr_o, 32'd0);
        rst = 0;
        tick();

        $display("[TB] directed load/store sequence");
        applyStimulus("lb",   1, 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234, 0, 1, 0, 0, 0,
                      1, 32'h8000_0003, 0, 8'h00, 32'hFFFF_FF80, 0, 4);
        applyStimulus("lhu",  1, 0, 3'b101, 32'h8000_0002, 0, 32'hBEEF_0000, 0, 0, 0, 0, 0,
                      1, 32'h8000_0002, 0, 8'h00, 32'h0000_BEEF, 0, 3);
        applyStimulus("sb",   0, 1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0, 0, 0, 0, 3, 0,
                      2, 32'h8000_0001, 32'h3456_AB00, 8'h02, 32'h0, 0, 5);
        applyStimulus("lwerr", 1, 0, 3'b010, 32'h8000_0000, 0, 32'hCAFE_F00D, 1, 0, 0, 0, 2,
                      1, 32'h8000_0000, 0, 8'h00, 32'hCAFE_F00D, 1, 3);
        applyStimulus("lh",   1, 0, 3'b001, 32'h8000_0002, 0, 32'h8001_0000, 0, 0, 1, 0, 0,
                      1, 32'h8000_0002, 0, 8'h00, 32'hFFFF_8001, 0, 4);
        applyStimulus("sh",   0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0,
                      2, 32'h8000_0002, 32'hBEEF_0000, 8'h0C, 32'h0, 0, 2);
        applyStimulus("sw",   0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0,
                      2, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F, 32'h0, 0, 3);
        applyStimulus("lbu",  1, 0, 3'b100, 32'h8000_0001, 0, 32'h0000_9A00, 0, 0, 0, 0, 0,
                      1, 32'h8000_0001, 0, 8'h00, 32'h0000_009A, 0, 3);
        applyStimulus("undef", 1, 0, 3'b111, 32'h8000_0008, 0, 32'h8765_4321, 0, 0, 0, 0, 0,
                      1, 32'h8000_0008, 0, 8'h00, 32'h8765_4321, 0, 3);
        applyStimulus("both", 1, 1, 3'b010, 32'h8000_0010, 32'h1111_1111, 32'h55AA_55AA, 0, 0, 0, 0, 0,
                      1, 32'h8000_0010, 0, 8'h00, 32'h55AA_55AA, 0, 3);
        applyStimulus("noop", 0, 0, 3'b010, 32'h8000_0020, 0, 0, 0, 0, 0, 0, 1,
                      0, 0, 0, 8'h00, 32'h0, 0, 1);
`ifdef LSU_MISALIGN_CHECK_EN
        applyStimulus("lwmis", 1, 0, 3'b010, 32'h8000_0002, 0, 32'h1122_3344, 0, 0, 0, 0, 0,
                      0, 0, 0, 8'h00, 32'h0, 1, 1);
        applyStimulus("lhmis", 1, 0, 3'b001, 32'h8000_0001, 0, 32'h0000_F00D, 0, 0, 0, 0, 0,
                      0, 0, 0, 8'h00, 32'h0, 1, 1);
`else
        applyStimulus("lwmis", 1, 0, 3'b010, 32'h8000_0002, 0, 32'h1122_3344, 0, 0, 0, 0, 0,
                      1, 32'h8000_0002, 0, 8'h00, 32'h1122_3344, 0, 3);
        applyStimulus("lhmis", 1, 0, 3'b001, 32'h8000_0001, 0, 32'h0000_F00D, 0, 0, 0, 0, 0,
                      1, 32'h8000_0001, 0, 8'h00, 32'hFFFF_F00D, 0, 3);
`endif

        $display("[TB] reset while waiting for read data");
        req_valid_i = 1; is_load_i = 1; mem_op_i = 3'b010; addr_i = 32'h8000_0100;
        tick();
        req_valid_i = 0; is_load_i = 0; arready_i = 1;
        tick();
        arready_i = 0;
        checkOutput("abort.in_r", {31'b0, rready_o}, 32'd1);
        rvalid_i = 1; rdata_i = 32'hFFFF_FFFF; rst = 1;
        tick();
        checkOutput("abort.rready", {31'b0, rready_o}, 32'd0);
        checkOutput("abort.res_valid", {31'b0, res_valid_o}, 32'd0);
        checkOutput("abort.req_ready", {31'b0, req_ready_o}, 32'd1);
        checkOutput("abort.arvalid", {31'b0, arvalid_o}, 32'd0);
        rst = 0; rvalid_i = 0;
        repeat (2) tick();
        checkOutput("abort.no_result", {31'b0, res_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
